alu_txn_frontend: RTL

Transaction front-end for `main_alu`: accepts operation requests on a valid/ready channel and registers the operands into an issue stage. It drives the combinational `main_alu` from that stage and captures `out`/`carry` into a response FIFO, which is drained on a second valid/ready channel. It sits between a command source (sequencer or bus bridge) and `main_alu`, and it is the consumer side of the ALU's operand/result interface.

---
 rtl/alu_txn_frontend.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_txn_frontend.sv
// Valid/ready transaction front-end for main_alu: one issue register stage feeding the
// ALU, and an in-order response FIFO drained on a second valid/ready channel.

module main_alu (
  input  logic [2:0]  opcode_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [5:0]  shift_i,
  output logic [63:0] out_o,
  output logic        carry_o
);
  logic [32:0] sum;
  logic [32:0] diff;

  // add/sub report carry/borrow; the shift group works on a 64-bit zero- or
  // sign-extended operand; rotate is 32-bit by shift[4:0].
  always_comb begin
    out_o   = '0;
    carry_o = 1'b0;
    sum     = {1'b0, a_i} + {1'b0, b_i};
    diff    = {1'b0, a_i} - {1'b0, b_i};
    case (opcode_i)
      3'b000: begin
        out_o   = {32'b0, sum[31:0]};
        carry_o = sum[32];
      end
      3'b001: begin
        out_o   = {32'b0, diff[31:0]};
        carry_o = diff[32];
      end
      3'b010: out_o = {32'b0, a_i} * {32'b0, b_i};
      3'b011: begin
        if (b_i != '0) out_o = {a_i % b_i, a_i / b_i};
      end
      3'b100: out_o = {32'b0, a_i} << shift_i;
      3'b101: out_o = {32'b0, a_i} >> shift_i;
      3'b110: out_o = $signed({{32{a_i[31]}}, a_i}) >>> shift_i;
      default: out_o = {32'b0, 32'(({a_i, a_i} << shift_i[4:0]) >> 32)};
    endcase
  end
endmodule

module alu_txn_frontend #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_opcode,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [5:0]       req_shift,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_out,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      txn_count,
  output logic             busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DepthC = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  typedef struct packed {
    logic [63:0]      out;
    logic             carry;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic             iss_valid_q, iss_valid_d;
  logic [2:0]       iss_opcode_q;
  logic [31:0]      iss_a_q, iss_b_q;
  logic [5:0]       iss_shift_q;
  logic [TAG_W-1:0] iss_tag_q;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      txn_count_q, txn_count_d;

  logic [63:0]      alu_out;
  logic             alu_carry;
  logic             accept, push, pop, div_zero;
  logic [CNT_W:0]   occupancy;
  entry_t           wr_entry, head;
  state_e           state;

  main_alu u_alu (
    .opcode_i (iss_opcode_q),
    .a_i      (iss_a_q),
    .b_i      (iss_b_q),
    .shift_i  (iss_shift_q),
    .out_o    (alu_out),
    .carry_o  (alu_carry)
  );

  // Ready counts the issue slot as occupied, so the capture write can never find the FIFO full.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, iss_valid_q};
  assign req_ready = occupancy < DepthC;
  assign accept    = req_valid && req_ready;
  assign push      = iss_valid_q;
  assign rsp_valid = count_q != '0;
  assign pop       = rsp_valid && rsp_ready;
  assign div_zero  = (iss_opcode_q == 3'b011) && (iss_b_q == '0);

  always_comb begin
    wr_entry       = '0;
    wr_entry.tag   = iss_tag_q;
    if (div_zero) begin
      wr_entry.err = 1'b1;
    end else begin
      wr_entry.out   = alu_out;
      wr_entry.carry = alu_carry;
    end
  end

  always_comb begin
    iss_valid_d = accept;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    txn_count_d = txn_count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      txn_count_d = txn_count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q  <= 1'b0;
      iss_opcode_q <= '0;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      iss_shift_q  <= '0;
      iss_tag_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      txn_count_q  <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      if (accept) begin
        iss_opcode_q <= req_opcode;
        iss_a_q      <= req_a;
        iss_b_q      <= req_b;
        iss_shift_q  <= req_shift;
        iss_tag_q    <= req_tag;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      txn_count_q <= txn_count_d;
    end
  end

  // Storage is not reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign rsp_out   = rsp_valid ? head.out   : '0;
  assign rsp_carry = rsp_valid ? head.carry : 1'b0;
  assign rsp_err   = rsp_valid ? head.err   : 1'b0;
  assign rsp_tag   = rsp_valid ? head.tag   : '0;
  assign txn_count = txn_count_q;

  always_comb begin
    state = IDLE;
    if (iss_valid_q)         state = ISSUE;
    else if (count_q != '0)  state = DRAIN;
  end

  assign busy = state != IDLE;
endmodule
